// File: rtl/blockram_request_controller.sv
// -----------------------------------------------------------------------------
// blockram_request_controller
//
// Front-end for one port of a dual-port block RAM. It accepts read and
// byte-masked write requests over a valid/ready handshake. It drives the RAM
// port combinationally from the accepted request. Read data returns one cycle
// after issue and is buffered, together with its tag, in a small response FIFO.
//
// Reads are admitted on credit. A read is only issued when a FIFO slot is
// guaranteed for its data. The RAM cannot be stalled, so this credit check is
// what keeps read data from being lost under response backpressure.
//
// Handshake semantics (both request and response sides):
//   A transfer happens on a rising clock edge where valid & ready are both high.
//   - request_ready_out depends only on registered state and reset_in.
//   - response_valid_out depends only on registered state and reset_in.
//   - The head fields (entry / entry_valid / tag) are meaningful only while
//     response_valid_out is high.
//
// Ports:
//   clk_in, reset_in            clock, synchronous active-high reset
//   request_*                   request channel (write_en == 0 means read)
//   ram_*_out                   RAM port drive (access enable, mask, addr, data)
//   ram_read_entry_in/valid_in  RAM read data and per-set valid bit, 1-cycle latency
//   response_*                  response channel, FIFO head
//   outstanding_count_out       buffered responses plus the read in flight
// -----------------------------------------------------------------------------
module blockram_request_controller #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / 8,
  parameter int TAG_WIDTH_IN_BITS          = 4,
  parameter int RESP_FIFO_DEPTH            = 4,
  localparam int CNT_W                     = $clog2(RESP_FIFO_DEPTH + 1)
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  // request channel
  input  logic                                  request_valid_in,
  output logic                                  request_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      request_set_addr_in,
  input  logic [WRITE_MASK_LEN-1:0]             request_write_en_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_write_entry_in,
  input  logic [TAG_WIDTH_IN_BITS-1:0]          request_tag_in,
  // RAM port
  output logic                                  ram_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]             ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]      ram_access_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_write_entry_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_read_entry_in,
  input  logic                                  ram_read_valid_in,
  // response channel
  output logic                                  response_valid_out,
  input  logic                                  response_ready_in,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] response_entry_out,
  output logic                                  response_entry_valid_out,
  output logic [TAG_WIDTH_IN_BITS-1:0]          response_tag_out,
  output logic [CNT_W-1:0]                      outstanding_count_out
);

  localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);

  // read in flight: issued last cycle, data on ram_read_* this cycle
  logic                                  r_pending_read;
  logic [TAG_WIDTH_IN_BITS-1:0]          r_pending_tag;

  // response FIFO storage and bookkeeping
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] r_fifo_entry [RESP_FIFO_DEPTH];
  logic                                  r_fifo_ev    [RESP_FIFO_DEPTH];
  logic [TAG_WIDTH_IN_BITS-1:0]          r_fifo_tag   [RESP_FIFO_DEPTH];
  logic [PTR_W-1:0]                      r_wr_ptr;
  logic [PTR_W-1:0]                      r_rd_ptr;
  logic [CNT_W-1:0]                      r_fifo_count;

  logic [CNT_W-1:0]                      w_outstanding;
  logic                                  w_ready;
  logic                                  w_accept;
  logic                                  w_read_accept;
  logic                                  w_fifo_empty;
  logic                                  w_push;
  logic                                  w_pop;

  // Credits: every buffered entry plus the read in flight holds a slot.
  // The credit invariant keeps this sum <= RESP_FIFO_DEPTH, so CNT_W bits suffice.
  assign w_outstanding = r_fifo_count + CNT_W'(r_pending_read);
  assign w_ready       = ~reset_in & (w_outstanding < CNT_W'(RESP_FIFO_DEPTH));
  assign w_accept      = request_valid_in & w_ready;
  assign w_read_accept = w_accept & (request_write_en_in == '0);

  assign w_fifo_empty  = (r_fifo_count == '0);
  // The data of the in-flight read is captured unconditionally; the credit
  // check at issue time guarantees a free slot for it.
  assign w_push        = r_pending_read;
  assign w_pop         = ~reset_in & ~w_fifo_empty & response_ready_in;

  // request side and RAM drive
  assign request_ready_out       = w_ready;
  assign ram_access_en_out       = w_accept;
  assign ram_write_en_out        = w_accept ? request_write_en_in : '0;
  assign ram_access_set_addr_out = request_set_addr_in;
  assign ram_write_entry_out     = request_write_entry_in;

  // response side: the head comes straight from storage
  assign response_valid_out       = ~reset_in & ~w_fifo_empty;
  assign response_entry_out       = r_fifo_entry[r_rd_ptr];
  assign response_entry_valid_out = r_fifo_ev[r_rd_ptr];
  assign response_tag_out         = r_fifo_tag[r_rd_ptr];
  assign outstanding_count_out    = reset_in ? '0 : w_outstanding;

  // Bookkeeping. Clearing r_pending_read in reset drops an in-flight read,
  // and also discards RAM data that arrives in the first cycle after reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_pending_read <= 1'b0;
      r_pending_tag  <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_fifo_count   <= '0;
    end else begin
      r_pending_read <= w_read_accept;
      if (w_read_accept) begin
        r_pending_tag <= request_tag_in;
      end
      // The pointers wrap naturally because the depth is a power of 2.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset; entries are only observed once counted.
  always_ff @(posedge clk_in) begin
    if (!reset_in && w_push) begin
      r_fifo_entry[r_wr_ptr] <= ram_read_entry_in;
      r_fifo_ev[r_wr_ptr]    <= ram_read_valid_in;
      r_fifo_tag[r_wr_ptr]   <= r_pending_tag;
    end
  end

endmodule

// File: tb/tb_blockram_request_controller.sv
// -----------------------------------------------------------------------------
// Bench for blockram_request_controller (64-bit entries, 64 sets, depth 4).
// The bench models the RAM itself. A reference model tracks the responses
// still owed, in request order, as queues. Each response is stamped with the
// cycle it becomes visible (accept cycle + 2). A compare process checks every
// DUT output against that model on each falling edge. Directed sequences add
// literal expectations at the boundary points.
// -----------------------------------------------------------------------------
module tb_blockram_request_controller;

  localparam int W     = 64;
  localparam int SETS  = 64;
  localparam int AW    = 6;
  localparam int MW    = 8;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk_in;
  logic          reset_in;
  logic          request_valid_in;
  logic          request_ready_out;
  logic [AW-1:0] request_set_addr_in;
  logic [MW-1:0] request_write_en_in;
  logic [W-1:0]  request_write_entry_in;
  logic [TW-1:0] request_tag_in;
  logic          ram_access_en_out;
  logic [MW-1:0] ram_write_en_out;
  logic [AW-1:0] ram_access_set_addr_out;
  logic [W-1:0]  ram_write_entry_out;
  logic [W-1:0]  ram_read_entry_in;
  logic          ram_read_valid_in;
  logic          response_valid_out;
  logic          response_ready_in;
  logic [W-1:0]  response_entry_out;
  logic          response_entry_valid_out;
  logic [TW-1:0] response_tag_out;
  logic [CW-1:0] outstanding_count_out;

  blockram_request_controller dut (
    .clk_in                   (clk_in),
    .reset_in                 (reset_in),
    .request_valid_in         (request_valid_in),
    .request_ready_out        (request_ready_out),
    .request_set_addr_in      (request_set_addr_in),
    .request_write_en_in      (request_write_en_in),
    .request_write_entry_in   (request_write_entry_in),
    .request_tag_in           (request_tag_in),
    .ram_access_en_out        (ram_access_en_out),
    .ram_write_en_out         (ram_write_en_out),
    .ram_access_set_addr_out  (ram_access_set_addr_out),
    .ram_write_entry_out      (ram_write_entry_out),
    .ram_read_entry_in        (ram_read_entry_in),
    .ram_read_valid_in        (ram_read_valid_in),
    .response_valid_out       (response_valid_out),
    .response_ready_in        (response_ready_in),
    .response_entry_out       (response_entry_out),
    .response_entry_valid_out (response_entry_valid_out),
    .response_tag_out         (response_tag_out),
    .outstanding_count_out    (outstanding_count_out)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- RAM model
  logic [W-1:0] ram_mem [SETS];
  logic         ram_vld [SETS];

  initial begin
    for (int i = 0; i < SETS; i++) begin
      ram_mem[i] = '0;
      ram_vld[i] = 1'b0;
    end
    ram_read_entry_in = '0;
    ram_read_valid_in = 1'b0;
  end

  always @(posedge clk_in) begin
    if (ram_access_en_out) begin
      if (ram_write_en_out == '0) begin
        ram_read_entry_in <= ram_mem[ram_access_set_addr_out];
        ram_read_valid_in <= ram_vld[ram_access_set_addr_out];
      end else begin
        for (int b = 0; b < MW; b++) begin
          if (ram_write_en_out[b]) begin
            ram_mem[ram_access_set_addr_out][b*8 +: 8] <= ram_write_entry_out[b*8 +: 8];
          end
        end
        ram_vld[ram_access_set_addr_out] <= 1'b1;
      end
    end else begin
      ram_read_entry_in <= {W{1'b1}};
      ram_read_valid_in <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0]  shadow_mem [SETS];
  logic          shadow_vld [SETS];
  logic [W-1:0]  exp_q[$];
  logic          ev_q[$];
  logic [TW-1:0] tag_q[$];
  int            due_q[$];
  int            pop_cyc_q[$];
  int            cyc = 0;

  initial begin
    for (int i = 0; i < SETS; i++) begin
      shadow_mem[i] = '0;
      shadow_vld[i] = 1'b0;
    end
  end

  always begin : compare_proc
    logic exp_ready, exp_valid, will_acc, will_pop;
    int   exp_out;
    @(negedge clk_in);
    exp_ready = !reset_in && (exp_q.size() < DEPTH);
    exp_out   = reset_in ? 0 : exp_q.size();
    exp_valid = !reset_in && (exp_q.size() > 0) && (due_q[0] <= cyc);
    will_acc  = exp_ready && request_valid_in;
    will_pop  = exp_valid && response_ready_in;
    chk("request_ready", request_ready_out, exp_ready);
    chk("outstanding", outstanding_count_out, exp_out);
    chk("response_valid", response_valid_out, exp_valid);
    if (exp_valid) begin
      chk("response_entry", response_entry_out, exp_q[0]);
      chk("response_entry_valid", response_entry_valid_out, ev_q[0]);
      chk("response_tag", response_tag_out, tag_q[0]);
    end
    chk("ram_access_en", ram_access_en_out, will_acc);
    chk("ram_write_en", ram_write_en_out, will_acc ? request_write_en_in : 8'h00);
    if (will_acc) begin
      chk("ram_addr", ram_access_set_addr_out, request_set_addr_in);
      chk("ram_wdata", ram_write_entry_out, request_write_entry_in);
    end
    @(posedge clk_in);
    if (reset_in) begin
      exp_q.delete();
      ev_q.delete();
      tag_q.delete();
      due_q.delete();
    end else begin
      if (will_pop) begin
        void'(exp_q.pop_front());
        void'(ev_q.pop_front());
        void'(tag_q.pop_front());
        void'(due_q.pop_front());
        pop_cyc_q.push_back(cyc);
      end
      if (will_acc) begin
        if (request_write_en_in == '0) begin
          exp_q.push_back(shadow_mem[request_set_addr_in]);
          ev_q.push_back(shadow_vld[request_set_addr_in]);
          tag_q.push_back(request_tag_in);
          due_q.push_back(cyc + 2);
        end else begin
          for (int b = 0; b < MW; b++) begin
            if (request_write_en_in[b]) begin
              shadow_mem[request_set_addr_in][b*8 +: 8] = request_write_entry_in[b*8 +: 8];
            end
          end
          shadow_vld[request_set_addr_in] = 1'b1;
        end
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic set_req(input logic [AW-1:0] addr, input logic [MW-1:0] we,
                         input logic [W-1:0] data, input logic [TW-1:0] tag);
    request_valid_in       = 1'b1;
    request_set_addr_in    = addr;
    request_write_en_in    = we;
    request_write_entry_in = data;
    request_tag_in         = tag;
  endtask

  // Present a request and wait (bounded) for its accept edge.
  task automatic req(input logic [AW-1:0] addr, input logic [MW-1:0] we,
                     input logic [W-1:0] data, input logic [TW-1:0] tag);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    set_req(addr, we, data, tag);
    while (!acc && n < 50) begin
      @(negedge clk_in);
      acc = request_ready_out;
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("req_accept_timeout", acc, 1'b1);
    request_valid_in = 1'b0;
  endtask

  // Single read into an empty FIFO with a hand-computed result.
  task automatic read_check(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                            input logic [W-1:0] exp_entry, input logic exp_ev);
    req(addr, 8'h00, '0, tag);
    @(negedge clk_in);
    chk("lat_t1_valid", response_valid_out, 1'b0);
    @(negedge clk_in);
    chk("lat_t2_valid", response_valid_out, 1'b1);
    chk("lat_t2_entry", response_entry_out, exp_entry);
    chk("lat_t2_tag", response_tag_out, tag);
    chk("lat_t2_entry_valid", response_entry_valid_out, exp_ev);
    @(posedge clk_in);
    #1;
  endtask

  // Hold the current request for n cycles while the FIFO is full.
  task automatic hold_stalled(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      chk("stall_ready", request_ready_out, 1'b0);
      chk("stall_access_en", ram_access_en_out, 1'b0);
      chk("stall_outstanding", outstanding_count_out, 3'd4);
      @(posedge clk_in);
      #1;
    end
  endtask

  // One-cycle pop pulse, then expect the held request to be accepted.
  task automatic pulse_pop(input logic [TW-1:0] exp_tag);
    response_ready_in = 1'b1;
    @(negedge clk_in);
    chk("pulse_head_tag", response_tag_out, exp_tag);
    chk("pulse_ready_still_low", request_ready_out, 1'b0);
    @(posedge clk_in);
    #1;
    response_ready_in = 1'b0;
    @(negedge clk_in);
    chk("post_pop_ready", request_ready_out, 1'b1);
    chk("post_pop_access_en", ram_access_en_out, 1'b1);
    @(posedge clk_in);
    #1;
    request_valid_in = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_in               = 1'b1;
    request_valid_in       = 1'b0;
    request_set_addr_in    = '0;
    request_write_en_in    = '0;
    request_write_entry_in = '0;
    request_tag_in         = '0;
    response_ready_in      = 1'b1;

    // reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_ready", request_ready_out, 1'b0);
    chk("rst_resp_valid", response_valid_out, 1'b0);
    chk("rst_outstanding", outstanding_count_out, 3'd0);
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;

    // 1: write then read back with tag 3
    req(6'd5, 8'hFF, 64'h1122334455667788, 4'd0);
    read_check(6'd5, 4'd3, 64'h1122334455667788, 1'b1);

    // 2: fill with four reads while the consumer stalls
    response_ready_in = 1'b0;
    req(6'd5, 8'h00, '0, 4'd0);
    req(6'd6, 8'h00, '0, 4'd1);
    req(6'd7, 8'h00, '0, 4'd2);
    req(6'd8, 8'h00, '0, 4'd3);
    @(negedge clk_in);
    chk("full_ready", request_ready_out, 1'b0);
    chk("full_outstanding", outstanding_count_out, 3'd4);
    @(posedge clk_in);
    #1;

    // 3: fifth read held off, one pop lets it in
    set_req(6'd5, 8'h00, '0, 4'd4);
    hold_stalled(3);
    pulse_pop(4'd0);

    // 5: write held off while full, one pop lets it in
    set_req(6'd7, 8'h0F, 64'hAAAABBBBCCCCDDDD, 4'd0);
    hold_stalled(3);
    pulse_pop(4'd1);

    // drain the rest (tags 2, 3, 4)
    response_ready_in = 1'b1;
    repeat (8) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk("drained_outstanding", outstanding_count_out, 3'd0);
    chk("drained_valid", response_valid_out, 1'b0);
    @(posedge clk_in);
    #1;

    // masked write merged into a zero entry
    read_check(6'd7, 4'd5, 64'h00000000CCCCDDDD, 1'b1);

    // 4: back-to-back reads, tags 0..7, consumer always ready
    pop_cyc_q.delete();
    for (int t = 0; t < 8; t++) begin
      req(6'(t % 2 == 0 ? 5 : 7), 8'h00, '0, 4'(t));
    end
    repeat (4) @(posedge clk_in);
    #1;
    chk("b2b_pops", 64'(pop_cyc_q.size()), 64'd8);
    if (pop_cyc_q.size() == 8) begin
      chk("b2b_no_bubbles", 64'(pop_cyc_q[7] - pop_cyc_q[0]), 64'd7);
    end

    // 6: reset in the cycle after a read accept drops the read
    response_ready_in = 1'b0;
    req(6'd5, 8'h00, '0, 4'd9);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("rst6_ready", request_ready_out, 1'b0);
    chk("rst6_valid", response_valid_out, 1'b0);
    chk("rst6_outstanding", outstanding_count_out, 3'd0);
    chk("rst6_access_en", ram_access_en_out, 1'b0);
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("post_rst_valid", response_valid_out, 1'b0);
      chk("post_rst_outstanding", outstanding_count_out, 3'd0);
      @(posedge clk_in);
      #1;
    end

    repeat (2) @(posedge clk_in);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
